operand_fetch: RTL and testbench

- Pipeline stage directly upstream of the register bank.
- Accepts decoded instructions and drives the bank's read ports and write port. Writeback results from later stages are routed through this block to reach the bank.
- Holds a per-register pending scoreboard and stalls RAW/WAW hazards.
- Presents registered operands to execute over a valid/ready handshake.

---
 rtl/opfetch_pkg.sv | 23 ++
 rtl/reg_scoreboard.sv | 40 ++++
 rtl/operand_fetch.sv | 143 ++++++++++++++
 tb/tb_operand_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// Shared definitions for the operand fetch stage: default widths, FSM encoding
// and the register-index to bank-address mapping.
package opfetch_pkg;

  localparam int DATA_W_DEF = 65;
  localparam int ADDR_W_DEF = 65;
  localparam int IDX_W_DEF  = 8;
  localparam int OP_W_DEF   = 6;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_HAZ = 1'b1
  } state_t;

  // The bank decodes the register index from address bits [IDX_W:1].
  function automatic logic [ADDR_W_DEF-1:0] idx_to_addr(input logic [IDX_W_DEF-1:0] idx);
    logic [ADDR_W_DEF-1:0] addr;
    addr = '0;
    addr[IDX_W_DEF:1] = idx;
    return addr;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard: one set port and one clear port (set wins
// on the same index), two source lookups and one destination lookup.
module reg_scoreboard
  import opfetch_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rs1_pend,
  output logic             rs2_pend,
  output logic             rd_pend
);

  localparam int NREG = 1 << IDX_W;

  logic [NREG-1:0] pending;

  // Clear is applied first so a same-index set overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_idx] <= 1'b0;
      if (set_en) pending[set_idx] <= 1'b1;
    end
  end

  assign rs1_pend = pending[rs1_idx];
  assign rs2_pend = pending[rs2_idx];
  assign rd_pend  = pending[rd_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: drives the register bank, tracks pending writes and
// stalls RAW/WAW hazards. Define OPFETCH_FWD_EN for same-cycle writeback bypass.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_op,
  input  logic [IDX_W-1:0]  dec_rs1,
  input  logic [IDX_W-1:0]  dec_rs2,
  input  logic [IDX_W-1:0]  dec_rd,
  input  logic              dec_wb,
  output logic [ADDR_W-1:0] rf_read_address1,
  output logic [ADDR_W-1:0] rf_read_address2,
  output logic              rf_read_en,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [IDX_W-1:0]  ex_rd,
  output logic              ex_wb,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic              stall
);

  state_t state, state_nxt;

  logic rs1_pend, rs2_pend, rd_pend;
  logic rs1_blk, rs2_blk, rd_blk;
  logic hazard, fire;
  logic [DATA_W-1:0] a_p0, b_p0;

  logic              vld_p1;
  logic [OP_W-1:0]   op_p1;
  logic [IDX_W-1:0]  rd_p1;
  logic              wb_p1;
  logic [DATA_W-1:0] a_p1, b_p1;

  assign rf_read_address1 = ADDR_W'(idx_to_addr(dec_rs1));
  assign rf_read_address2 = ADDR_W'(idx_to_addr(dec_rs2));
  assign rf_read_en       = 1'b1;
  assign rf_write_address = ADDR_W'(idx_to_addr(wb_rd));
  assign rf_write_data    = wb_data;
  assign rf_write_en      = wb_valid;

  reg_scoreboard #(.IDX_W(IDX_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (fire && dec_wb),
    .set_idx  (dec_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .rs1_idx  (dec_rs1),
    .rs2_idx  (dec_rs2),
    .rd_idx   (dec_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

`ifdef OPFETCH_FWD_EN
  logic rs1_fwd, rs2_fwd, rd_fwd;
  assign rs1_fwd = wb_valid && (wb_rd == dec_rs1);
  assign rs2_fwd = wb_valid && (wb_rd == dec_rs2);
  assign rd_fwd  = wb_valid && (wb_rd == dec_rd);
  assign rs1_blk = rs1_pend && !rs1_fwd;
  assign rs2_blk = rs2_pend && !rs2_fwd;
  assign rd_blk  = rd_pend && !rd_fwd;
  assign a_p0    = rs1_fwd ? wb_data : rf_read_data1;
  assign b_p0    = rs2_fwd ? wb_data : rf_read_data2;
`else
  // Without bypass a source waits until the bank has committed the writeback.
  assign rs1_blk = rs1_pend;
  assign rs2_blk = rs2_pend;
  assign rd_blk  = rd_pend;
  assign a_p0    = rf_read_data1;
  assign b_p0    = rf_read_data2;
`endif

  assign hazard    = dec_valid && (rs1_blk || rs2_blk || (dec_wb && rd_blk));
  assign dec_ready = !hazard && (!vld_p1 || ex_ready);
  assign fire      = dec_valid && dec_ready;

  // p0 -> p1: operand registers toward execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      op_p1  <= '0;
      rd_p1  <= '0;
      wb_p1  <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
    end else if (fire) begin
      vld_p1 <= 1'b1;
      op_p1  <= dec_op;
      rd_p1  <= dec_rd;
      wb_p1  <= dec_wb;
      a_p1   <= a_p0;
      b_p1   <= b_p0;
    end else if (ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign ex_valid = vld_p1;
  assign ex_op    = op_p1;
  assign ex_rd    = rd_p1;
  assign ex_wb    = wb_p1;
  assign ex_a     = a_p1;
  assign ex_b     = b_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (hazard)  state_nxt = ST_HAZ;
      ST_HAZ:  if (!hazard) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign stall = (state == ST_HAZ);

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register bank; expected
// values are hand-computed and adjust when OPFETCH_FWD_EN is defined.
module tb_operand_fetch;

  logic         clk;
  logic         rst_n;
  logic         dec_valid;
  logic         dec_ready;
  logic [5:0]   dec_op;
  logic [7:0]   dec_rs1, dec_rs2, dec_rd;
  logic         dec_wb;
  logic [64:0]  rf_read_address1, rf_read_address2;
  logic         rf_read_en;
  logic [64:0]  rf_read_data1, rf_read_data2;
  logic [64:0]  rf_write_address;
  logic [64:0]  rf_write_data;
  logic         rf_write_en;
  logic         wb_valid;
  logic [7:0]   wb_rd;
  logic [64:0]  wb_data;
  logic         ex_valid;
  logic         ex_ready;
  logic [5:0]   ex_op;
  logic [7:0]   ex_rd;
  logic         ex_wb;
  logic [64:0]  ex_a, ex_b;
  logic         stall;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_op           (dec_op),
    .dec_rs1          (dec_rs1),
    .dec_rs2          (dec_rs2),
    .dec_rd           (dec_rd),
    .dec_wb           (dec_wb),
    .rf_read_address1 (rf_read_address1),
    .rf_read_address2 (rf_read_address2),
    .rf_read_en       (rf_read_en),
    .rf_read_data1    (rf_read_data1),
    .rf_read_data2    (rf_read_data2),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_en      (rf_write_en),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_op            (ex_op),
    .ex_rd            (ex_rd),
    .ex_wb            (ex_wb),
    .ex_a             (ex_a),
    .ex_b             (ex_b),
    .stall            (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bank: combinational read, write committed at posedge.
  logic [64:0] bank [256];
  logic        bank_init;
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 256; i++) bank[i] <= '0;
      bank[3] <= 65'd7;
      bank[4] <= 65'd9;
    end else if (rf_write_en) begin
      bank[rf_write_address[8:1]] <= rf_write_data;
    end
  end
  assign rf_read_data1 = bank[rf_read_address1[8:1]];
  assign rf_read_data2 = bank[rf_read_address2[8:1]];

  logic [255:0] pend;
  assign pend = dut.u_sb.pending;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dec(input logic v, input logic [7:0] rs1, input logic [7:0] rs2,
                           input logic [7:0] rd, input logic wb, input logic [5:0] op);
    dec_valid = v;
    dec_rs1   = rs1;
    dec_rs2   = rs2;
    dec_rd    = rd;
    dec_wb    = wb;
    dec_op    = op;
  endtask

  task automatic drive_wb(input logic v, input logic [7:0] rd, input logic [64:0] data);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  initial begin
    rst_n     = 1'b0;
    bank_init = 1'b1;
    ex_ready  = 1'b1;
    drive_dec(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6'd0);
    drive_wb(1'b0, 8'd0, 65'd0);
    step();
    step();
    check_val("rst_ex_valid", 256'(ex_valid), 256'd0);
    check_val("rst_stall", 256'(stall), 256'd0);
    check_val("rst_ex_a", 256'(ex_a), 256'd0);
    check_val("rst_pending", pend, 256'd0);
    check_val("rst_dec_ready", 256'(dec_ready), 256'd1);
    check_val("rd_en", 256'(rf_read_en), 256'd1);
    rst_n     = 1'b1;
    bank_init = 1'b0;
    step();

    // First issue: r3=7, r4=9 -> rd=5
    drive_dec(1'b1, 8'd3, 8'd4, 8'd5, 1'b1, 6'h15);
    #1;
    check_val("t1_dec_ready", 256'(dec_ready), 256'd1);
    check_val("t1_raddr1", 256'(rf_read_address1), 256'd6);
    check_val("t1_raddr2", 256'(rf_read_address2), 256'd8);
    step();
    check_val("t1_ex_valid", 256'(ex_valid), 256'd1);
    check_val("t1_ex_a", 256'(ex_a), 256'd7);
    check_val("t1_ex_b", 256'(ex_b), 256'd9);
    check_val("t1_ex_rd", 256'(ex_rd), 256'd5);
    check_val("t1_ex_op", 256'(ex_op), 256'h15);
    check_val("t1_ex_wb", 256'(ex_wb), 256'd1);
    check_val("t1_pend5", 256'(pend[5]), 256'd1);

    // RAW on r5
    drive_dec(1'b1, 8'd5, 8'd4, 8'd6, 1'b1, 6'h22);
    #1;
    check_val("raw_dec_ready", 256'(dec_ready), 256'd0);
    step();
    check_val("raw_stall", 256'(stall), 256'd1);
    check_val("raw_ex_drained", 256'(ex_valid), 256'd0);
    drive_wb(1'b1, 8'd5, 65'd42);
    #1;
    check_val("raw_wr_en", 256'(rf_write_en), 256'd1);
    check_val("raw_wr_addr", 256'(rf_write_address), 256'd10);
`ifdef OPFETCH_FWD_EN
    check_val("raw_fwd_ready", 256'(dec_ready), 256'd1);
    step();
    drive_wb(1'b0, 8'd0, 65'd0);
`else
    check_val("raw_nofwd_ready", 256'(dec_ready), 256'd0);
    step();
    drive_wb(1'b0, 8'd0, 65'd0);
    #1;
    check_val("raw_nofwd_ready2", 256'(dec_ready), 256'd1);
    step();
`endif
    check_val("raw_ex_valid", 256'(ex_valid), 256'd1);
    check_val("raw_ex_a", 256'(ex_a), 256'd42);
    check_val("raw_ex_b", 256'(ex_b), 256'd9);
    check_val("raw_ex_rd", 256'(ex_rd), 256'd6);
    check_val("raw_pend5", 256'(pend[5]), 256'd0);

    // Backpressure: hold ex_ready low for 3 cycles
    ex_ready = 1'b0;
    drive_dec(1'b1, 8'd3, 8'd4, 8'd9, 1'b1, 6'h01);
    #1;
    check_val("bp_dec_ready0", 256'(dec_ready), 256'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("bp_ex_valid", 256'(ex_valid), 256'd1);
      check_val("bp_ex_a", 256'(ex_a), 256'd42);
      check_val("bp_ex_rd", 256'(ex_rd), 256'd6);
      check_val("bp_dec_ready", 256'(dec_ready), 256'd0);
    end
    ex_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 256'(dec_ready), 256'd1);
    step();
    check_val("bp_next_rd", 256'(ex_rd), 256'd9);
    check_val("bp_next_a", 256'(ex_a), 256'd7);
    check_val("bp_next_op", 256'(ex_op), 256'h01);

    // Same-cycle set/clear on r9
    drive_dec(1'b1, 8'd1, 8'd2, 8'd9, 1'b1, 6'h02);
    drive_wb(1'b1, 8'd9, 65'd55);
    #1;
`ifdef OPFETCH_FWD_EN
    check_val("sc_fwd_ready", 256'(dec_ready), 256'd1);
    step();
`else
    check_val("sc_waw_ready", 256'(dec_ready), 256'd0);
    step();
    check_val("sc_cleared", 256'(pend[9]), 256'd0);
    check_val("sc_ready2", 256'(dec_ready), 256'd1);
    step();
`endif
    drive_dec(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6'd0);
    drive_wb(1'b0, 8'd0, 65'd0);
    check_val("sc_pend9", 256'(pend[9]), 256'd1);
    check_val("sc_ex_rd", 256'(ex_rd), 256'd9);

    // Stray writeback to a non-pending register
    drive_wb(1'b1, 8'd200, 65'd123);
    #1;
    check_val("stray_wr_en", 256'(rf_write_en), 256'd1);
    check_val("stray_wr_addr", 256'(rf_write_address), 256'd400);
    check_val("stray_wr_data", 256'(rf_write_data), 256'd123);
    step();
    drive_wb(1'b0, 8'd0, 65'd0);
    check_val("stray_pending", pend, (256'd1 << 6) | (256'd1 << 9));

    // Reset while stalled on r5
    drive_dec(1'b1, 8'd3, 8'd4, 8'd5, 1'b1, 6'h03);
    step();
    drive_dec(1'b1, 8'd5, 8'd3, 8'd7, 1'b0, 6'h04);
    step();
    check_val("mr_stall", 256'(stall), 256'd1);
    check_val("mr_dec_ready", 256'(dec_ready), 256'd0);
    rst_n = 1'b0;
    #1;
    check_val("mr_pending", pend, 256'd0);
    check_val("mr_ex_valid", 256'(ex_valid), 256'd0);
    check_val("mr_stall_clr", 256'(stall), 256'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_val("mr_post_ready", 256'(dec_ready), 256'd1);
    step();
    check_val("mr_issue_valid", 256'(ex_valid), 256'd1);
    check_val("mr_issue_stall", 256'(stall), 256'd0);
    check_val("mr_issue_a", 256'(ex_a), 256'd42);
    check_val("mr_issue_b", 256'(ex_b), 256'd7);
    check_val("mr_issue_rd", 256'(ex_rd), 256'd7);
    check_val("mr_issue_wb", 256'(ex_wb), 256'd0);
    drive_dec(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 6'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
